// File: rtl/bp_be_pkg.sv
// Shared types for the FMA/IMUL writeback collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_be_pkg;

  // RISC-V accrued exception flags, MSB first: NV, DZ, OF, UF, NX.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } rv64_fflags_s;

  localparam int bp_be_reg_addr_width_gp = 5;
  localparam int bp_be_fp_rec_width_gp   = 65;

  // One in-flight op as tracked by a tag chain stage.
  typedef struct packed {
    logic                               v;
    logic [bp_be_reg_addr_width_gp-1:0] rd;
  } bp_be_wb_tag_s;

  // FP register image: precision flag plus recoded value.
  typedef struct packed {
    logic                             sp_not_dp;
    logic [bp_be_fp_rec_width_gp-1:0] rec;
  } bp_be_fp_reg_s;

endpackage

// File: rtl/bp_be_wb_tag_chain.sv
// Latency-aligned tag chain carrying {v, rd} for ops issued into a fixed-latency pipe.
// Latency: an op inserted in cycle t is at the tail in cycle t+els_p-1 (same cycle if els_p == 1).
// Backpressure: none; shifts every cycle, flush drops the insert and clears all valids on the next edge.
module bp_be_wb_tag_chain #(
  parameter int els_p      = 4,
  parameter int rd_width_p = 5,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    insert_v_i,
  input  logic [rd_width_p-1:0]   insert_rd_i,
  input  logic                    flush_i,
  output logic                    tail_v_o,
  output logic [rd_width_p-1:0]   tail_rd_o,
  output logic [cnt_width_lp-1:0] count_o
);

  if (els_p == 1) begin : g_pass
    // Single-cycle pipe: the issuing op is already at the tail, nothing is stored.
    always_comb begin
      tail_v_o  = insert_v_i & ~flush_i;
      tail_rd_o = insert_rd_i;
      count_o   = '0;
    end
  end else begin : g_regs
    localparam int stg_lp = els_p - 1;

    logic [stg_lp-1:0]                 v_r;
    logic [stg_lp-1:0][rd_width_p-1:0] rd_r;

    // Shift register of tags; the tail stage simply falls off the end.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        v_r  <= '0;
        rd_r <= '0;
      end else begin
        v_r[0]  <= insert_v_i & ~flush_i;
        rd_r[0] <= insert_rd_i;
        for (int i = 1; i < stg_lp; i++) begin
          v_r[i]  <= v_r[i-1] & ~flush_i;
          rd_r[i] <= rd_r[i-1];
        end
      end
    end

    // Live-tag count and tail view, both straight from the stage registers.
    always_comb begin
      count_o = '0;
      for (int i = 0; i < stg_lp; i++) begin
        count_o = count_o + cnt_width_lp'(v_r[i]);
      end
      tail_v_o  = v_r[stg_lp-1];
      tail_rd_o = rd_r[stg_lp-1];
    end
  end

endmodule

// File: rtl/bp_be_fma_wb_collector.sv
// Pairs untagged fixed-latency IMUL/FMA results with their destination regs and drops flushed ones.
// Latency: writeback is registered, one cycle after the pipe result meets its tag at the chain tail.
// Backpressure: none; the pipe never stalls, results with no live tag are dropped silently.
module bp_be_fma_wb_collector
  import bp_be_pkg::*;
#(
  parameter int imul_latency_p   = 4,
  parameter int fma_latency_p    = 5,
  parameter int reg_addr_width_p = 5,
  parameter int int_data_width_p = 64,
  parameter int fp_data_width_p  = 66,
  localparam int inflight_width_lp = $clog2(imul_latency_p + fma_latency_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         issue_v_i,
  input  logic                         issue_imul_i,
  input  logic [reg_addr_width_p-1:0]  issue_rd_i,
  input  logic                         flush_i,
  input  logic                         imul_v_i,
  input  logic [int_data_width_p-1:0]  imul_data_i,
  input  logic                         fma_v_i,
  input  logic [fp_data_width_p-1:0]   fma_data_i,
  input  logic [4:0]                   fma_fflags_i,
  input  logic                         fflags_clear_i,
  output logic                         int_wb_v_o,
  output logic [reg_addr_width_p-1:0]  int_wb_rd_o,
  output logic [int_data_width_p-1:0]  int_wb_data_o,
  output logic                         fp_wb_v_o,
  output logic [reg_addr_width_p-1:0]  fp_wb_rd_o,
  output logic [fp_data_width_p-1:0]   fp_wb_data_o,
  output logic [4:0]                   fflags_o,
  output logic [inflight_width_lp-1:0] inflight_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int imul_cnt_width_lp = $clog2(imul_latency_p + 1);
  localparam int fma_cnt_width_lp  = $clog2(fma_latency_p + 1);

  logic                         imul_tail_v, fma_tail_v;
  logic [reg_addr_width_p-1:0]  imul_tail_rd, fma_tail_rd;
  logic [imul_cnt_width_lp-1:0] imul_cnt;
  logic [fma_cnt_width_lp-1:0]  fma_cnt;

  logic imul_match, fma_match, imul_miss, fma_miss;
  rv64_fflags_s fflags_r;

  bp_be_wb_tag_chain #(
    .els_p      (imul_latency_p),
    .rd_width_p (reg_addr_width_p)
  ) imul_chain (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .insert_v_i  (issue_v_i & issue_imul_i),
    .insert_rd_i (issue_rd_i),
    .flush_i     (flush_i),
    .tail_v_o    (imul_tail_v),
    .tail_rd_o   (imul_tail_rd),
    .count_o     (imul_cnt)
  );

  bp_be_wb_tag_chain #(
    .els_p      (fma_latency_p),
    .rd_width_p (reg_addr_width_p)
  ) fma_chain (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .insert_v_i  (issue_v_i & ~issue_imul_i),
    .insert_rd_i (issue_rd_i),
    .flush_i     (flush_i),
    .tail_v_o    (fma_tail_v),
    .tail_rd_o   (fma_tail_rd),
    .count_o     (fma_cnt)
  );

  // Tail pairing; flush is deliberately absent since a tail op has already completed.
  always_comb begin
    imul_match = imul_tail_v &  imul_v_i;
    imul_miss  = imul_tail_v & ~imul_v_i;
    fma_match  = fma_tail_v  &  fma_v_i;
    fma_miss   = fma_tail_v  & ~fma_v_i;
    inflight_o = inflight_width_lp'(imul_cnt) + inflight_width_lp'(fma_cnt);
    busy_o     = (inflight_o != '0);
  end

  // Integer writeback register; rd/data hold between writebacks.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      int_wb_v_o    <= 1'b0;
      int_wb_rd_o   <= '0;
      int_wb_data_o <= '0;
    end else begin
      int_wb_v_o <= imul_match;
      if (imul_match) begin
        int_wb_rd_o   <= imul_tail_rd;
        int_wb_data_o <= imul_data_i;
      end
    end
  end

  // FP writeback register; rd/data hold between writebacks.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fp_wb_v_o    <= 1'b0;
      fp_wb_rd_o   <= '0;
      fp_wb_data_o <= '0;
    end else begin
      fp_wb_v_o <= fma_match;
      if (fma_match) begin
        fp_wb_rd_o   <= fma_tail_rd;
        fp_wb_data_o <= fma_data_i;
      end
    end
  end

  // Sticky flags: the clear acts on the old value only, so a flag landing in the clear cycle survives.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fflags_r <= '0;
    end else begin
      fflags_r <= rv64_fflags_s'(({5{~fflags_clear_i}} & fflags_r) | ({5{fma_match}} & fma_fflags_i));
    end
  end

  // A live tag reaching the tail without its pipe result is a protocol error, sticky until reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_o <= 1'b0;
    end else if (imul_miss | fma_miss) begin
      err_o <= 1'b1;
    end
  end

  assign fflags_o = fflags_r;

endmodule

// File: tb/tb_bp_be_fma_wb_collector.sv
module tb_bp_be_fma_wb_collector;
  import bp_be_pkg::*;

  localparam int IL = 4;
  localparam int FL = 5;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        issue_v_i, issue_imul_i, flush_i;
  logic [4:0]  issue_rd_i;
  logic        imul_v_i, fma_v_i, fflags_clear_i;
  logic [63:0] imul_data_i;
  logic [65:0] fma_data_i;
  logic [4:0]  fma_fflags_i;
  logic        int_wb_v_o, fp_wb_v_o, busy_o, err_o;
  logic [4:0]  int_wb_rd_o, fp_wb_rd_o, fflags_o;
  logic [63:0] int_wb_data_o;
  logic [65:0] fp_wb_data_o;
  logic [3:0]  inflight_o;

  always #5 clk_i = ~clk_i;

  bp_be_fma_wb_collector #(
    .imul_latency_p(IL), .fma_latency_p(FL), .reg_addr_width_p(5),
    .int_data_width_p(64), .fp_data_width_p(66)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .issue_v_i(issue_v_i), .issue_imul_i(issue_imul_i), .issue_rd_i(issue_rd_i),
    .flush_i(flush_i),
    .imul_v_i(imul_v_i), .imul_data_i(imul_data_i),
    .fma_v_i(fma_v_i), .fma_data_i(fma_data_i), .fma_fflags_i(fma_fflags_i),
    .fflags_clear_i(fflags_clear_i),
    .int_wb_v_o(int_wb_v_o), .int_wb_rd_o(int_wb_rd_o), .int_wb_data_o(int_wb_data_o),
    .fp_wb_v_o(fp_wb_v_o), .fp_wb_rd_o(fp_wb_rd_o), .fp_wb_data_o(fp_wb_data_o),
    .fflags_o(fflags_o), .inflight_o(inflight_o), .busy_o(busy_o), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then land #1 after the edge that samples them.
  task automatic step(input logic iv, input logic imul, input logic [4:0] rd, input logic fl,
                      input logic imv, input logic [63:0] idat, input logic fv,
                      input logic [65:0] fdat, input logic [4:0] ffl, input logic clr);
    issue_v_i = iv; issue_imul_i = imul; issue_rd_i = rd; flush_i = fl;
    imul_v_i = imv; imul_data_i = idat; fma_v_i = fv; fma_data_i = fdat;
    fma_fflags_i = ffl; fflags_clear_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 0, 0, 64'd0, 0, 66'd0, 5'd0, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic iv; logic imul; logic [4:0] rd; logic fl;
    logic imv; logic [63:0] idat; logic fv; logic [65:0] fdat; logic [4:0] ffl; logic clr;
    logic e_iv; logic [4:0] e_ird; logic e_fv; logic [4:0] e_frd;
    logic [4:0] e_ffl; logic [3:0] e_inf; logic e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic iv, logic imul, logic [4:0] rd, logic fl,
                              logic imv, logic [63:0] idat, logic fv, logic [65:0] fdat,
                              logic [4:0] ffl, logic clr,
                              logic e_iv, logic [4:0] e_ird, logic e_fv, logic [4:0] e_frd,
                              logic [4:0] e_ffl, logic [3:0] e_inf, logic e_err);
    vec_t v;
    v.iv = iv; v.imul = imul; v.rd = rd; v.fl = fl;
    v.imv = imv; v.idat = idat; v.fv = fv; v.fdat = fdat; v.ffl = ffl; v.clr = clr;
    v.e_iv = e_iv; v.e_ird = e_ird; v.e_fv = e_fv; v.e_frd = e_frd;
    v.e_ffl = e_ffl; v.e_inf = e_inf; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit            imul;
    bp_be_wb_tag_s tag;
    int            due;
  } pend_t;

  pend_t       ops[$];
  int          cur;
  logic        m_int_v, m_fp_v, m_err;
  logic [4:0]  m_int_rd, m_fp_rd, m_ffl;
  logic [63:0] m_int_data;
  logic [65:0] m_fp_data;

  function automatic void model_reset();
    ops.delete();
    m_int_v = 0; m_fp_v = 0; m_err = 0; m_int_rd = 0; m_fp_rd = 0; m_ffl = 0;
    m_int_data = 0; m_fp_data = 0;
  endfunction

  // Each live op is due at the cycle its pipe result shows up: issue cycle + latency - 1.
  function automatic void model_step(logic iv, logic imul, logic [4:0] rd, logic fl,
                                     logic imv, logic [63:0] idat, logic fv,
                                     logic [65:0] fdat, logic [4:0] ffl, logic clr);
    bit hit_i = 0;
    bit hit_f = 0;
    logic [4:0] rd_i = 0;
    logic [4:0] rd_f = 0;
    pend_t keep[$];
    pend_t p;
    if (iv && !fl) begin
      p.imul = imul; p.tag.v = 1'b1; p.tag.rd = rd;
      p.due = cur + (imul ? IL : FL) - 1;
      ops.push_back(p);
    end
    foreach (ops[k]) begin
      if (ops[k].due == cur) begin
        if (ops[k].imul) begin hit_i = 1; rd_i = ops[k].tag.rd; end
        else             begin hit_f = 1; rd_f = ops[k].tag.rd; end
      end else begin
        keep.push_back(ops[k]);
      end
    end
    ops = keep;
    if (fl) ops.delete();
    m_int_v = hit_i && imv;
    if (m_int_v) begin m_int_rd = rd_i; m_int_data = idat; end
    m_fp_v = hit_f && fv;
    if (m_fp_v) begin m_fp_rd = rd_f; m_fp_data = fdat; end
    if ((hit_i && !imv) || (hit_f && !fv)) m_err = 1;
    m_ffl = (clr ? 5'd0 : m_ffl) | (m_fp_v ? ffl : 5'd0);
    cur++;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, " int_v"},   128'(int_wb_v_o),    128'(m_int_v));
    chk({tag, " int_rd"},  128'(int_wb_rd_o),   128'(m_int_rd));
    chk({tag, " int_dat"}, 128'(int_wb_data_o), 128'(m_int_data));
    chk({tag, " fp_v"},    128'(fp_wb_v_o),     128'(m_fp_v));
    chk({tag, " fp_rd"},   128'(fp_wb_rd_o),    128'(m_fp_rd));
    chk({tag, " fp_dat"},  128'(fp_wb_data_o),  128'(m_fp_data));
    chk({tag, " fflags"},  128'(fflags_o),      128'(m_ffl));
    chk({tag, " inflt"},   128'(inflight_o),    128'(ops.size()));
    chk({tag, " busy"},    128'(busy_o),        128'(ops.size() != 0));
    chk({tag, " err"},     128'(err_o),         128'(m_err));
  endtask

  bit hist_imul [0:3999];
  bit hist_fma  [0:3999];

  initial begin
    reset_i = 1'b1;
    issue_v_i = 0; issue_imul_i = 0; issue_rd_i = 0; flush_i = 0;
    imul_v_i = 0; imul_data_i = 0; fma_v_i = 0; fma_data_i = 0;
    fma_fflags_i = 0; fflags_clear_i = 0;
    #1;
    model_reset();
    chk_model("reset");
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // imul rd7 round trip, latency 4
    add(1,1,5'd7,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd1,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd1,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd1,0);
    add(0,0,5'd0,0, 1,64'h1234,0,66'd0,5'd0,0, 1,5'd7,0,5'd0, 5'd0,4'd0,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd0,0);
    // fma rd3 then imul rd9 land together
    add(1,0,5'd3,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd1,0);
    add(1,1,5'd9,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd2,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd2,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'd0,4'd2,0);
    add(0,0,5'd0,0, 1,64'hAAAA_5555_0000_FFFF,1,66'h2_1234_5678_9ABC_DEF0,5'b00001,0,
        1,5'd9,1,5'd3, 5'b00001,4'd0,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd0,0);
    // fma rd2 flushed, its late result is dropped silently
    add(1,0,5'd2,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd1,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd1,0);
    add(0,0,5'd0,1, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd0,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd0,0);
    add(0,0,5'd0,0, 0,64'd0,1,66'h3_FFFF_0000_FFFF_0000,5'b11111,0,
        0,5'd0,0,5'd0, 5'b00001,4'd0,0);
    // flag accumulation, then a clear coinciding with a new flag
    add(1,0,5'd4,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd1,0);
    add(1,0,5'd5,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd2,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd2,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00001,4'd2,0);
    add(0,0,5'd0,0, 0,64'd0,1,66'h1_0000_0000_0000_00AB,5'b10000,0,
        0,5'd0,1,5'd4, 5'b10001,4'd1,0);
    add(0,0,5'd0,0, 0,64'd0,1,66'h0_8000_0000_0000_00CD,5'b00100,1,
        0,5'd0,1,5'd5, 5'b00100,4'd0,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00100,4'd0,0);
    // imul rd1 whose pipe result never shows up
    add(1,1,5'd1,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00100,4'd1,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00100,4'd1,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00100,4'd1,0);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00100,4'd0,1);
    add(0,0,5'd0,0, 0,64'd0,0,66'd0,5'd0,0,  0,5'd0,0,5'd0, 5'b00100,4'd0,1);

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].imul, vecs[i].rd, vecs[i].fl, vecs[i].imv, vecs[i].idat,
           vecs[i].fv, vecs[i].fdat, vecs[i].ffl, vecs[i].clr);
      chk($sformatf("vec%0d int_v", i), 128'(int_wb_v_o), 128'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        chk($sformatf("vec%0d int_rd", i),  128'(int_wb_rd_o),   128'(vecs[i].e_ird));
        chk($sformatf("vec%0d int_dat", i), 128'(int_wb_data_o), 128'(vecs[i].idat));
      end
      chk($sformatf("vec%0d fp_v", i), 128'(fp_wb_v_o), 128'(vecs[i].e_fv));
      if (vecs[i].e_fv) begin
        chk($sformatf("vec%0d fp_rd", i),  128'(fp_wb_rd_o),   128'(vecs[i].e_frd));
        chk($sformatf("vec%0d fp_dat", i), 128'(fp_wb_data_o), 128'(vecs[i].fdat));
      end
      chk($sformatf("vec%0d fflags", i), 128'(fflags_o),   128'(vecs[i].e_ffl));
      chk($sformatf("vec%0d inflt", i),  128'(inflight_o), 128'(vecs[i].e_inf));
      chk($sformatf("vec%0d busy", i),   128'(busy_o),     128'(vecs[i].e_inf != 0));
      chk($sformatf("vec%0d err", i),    128'(err_o),      128'(vecs[i].e_err));
    end

    // Async reset with three live tags; the stale pipe results afterwards must vanish.
    step(1, 1, 5'd10, 0, 0, 64'd0, 0, 66'd0, 5'd0, 0);
    step(1, 0, 5'd11, 0, 0, 64'd0, 0, 66'd0, 5'd0, 0);
    step(1, 1, 5'd12, 0, 0, 64'd0, 0, 66'd0, 5'd0, 0);
    chk("mid inflt pre", 128'(inflight_o), 128'(3));
    #2 reset_i = 1'b1;
    #1;
    chk("mid inflt",  128'(inflight_o), 128'(0));
    chk("mid busy",   128'(busy_o),     128'(0));
    chk("mid err",    128'(err_o),      128'(0));
    chk("mid fflags", 128'(fflags_o),   128'(0));
    chk("mid int_rd", 128'(int_wb_rd_o), 128'(0));
    #2 reset_i = 1'b0;
    step(0, 0, 5'd0, 0, 1, 64'hDEAD, 0, 66'd0, 5'd0, 0);
    chk("post int_v", 128'(int_wb_v_o), 128'(0));
    idle();
    step(0, 0, 5'd0, 0, 1, 64'hBEEF, 1, 66'h5, 5'b01000, 0);
    chk("post2 int_v",  128'(int_wb_v_o), 128'(0));
    chk("post2 fp_v",   128'(fp_wb_v_o),  128'(0));
    chk("post2 err",    128'(err_o),      128'(0));
    chk("post2 fflags", 128'(fflags_o),   128'(0));
    chk("post2 inflt",  128'(inflight_o), 128'(0));

    // Randomized traffic: the pipe echoes every issue (flushed or not) after its latency.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic iv, imul, fl, imv, fv, clr;
      logic [4:0]  rd, ffl;
      logic [63:0] idat;
      logic [95:0] wide;
      bp_be_fp_reg_s fr;
      cur = c;
      hist_imul[c] = 0;
      hist_fma[c]  = 0;
      if (c % 700 == 699) begin
        reset_i = 1'b1;
        idle();
        model_reset();
        chk_model($sformatf("rnd%0d rst", c));
        reset_i = 1'b0;
        continue;
      end
      iv   = 1'($urandom_range(0, 1));
      imul = 1'($urandom_range(0, 1));
      rd   = 5'($urandom());
      fl   = ($urandom_range(0, 19) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      ffl  = 5'($urandom());
      idat = {$urandom(), $urandom()};
      wide = {$urandom(), $urandom(), $urandom()};
      fr.sp_not_dp = wide[95];
      fr.rec       = wide[64:0];
      hist_imul[c] = iv & imul;
      hist_fma[c]  = iv & ~imul;
      imv = (c >= IL - 1) ? hist_imul[c-(IL-1)] : 1'b0;
      fv  = (c >= FL - 1) ? hist_fma[c-(FL-1)]  : 1'b0;
      if ($urandom_range(0, 299) == 0) imv = ~imv;
      if ($urandom_range(0, 299) == 0) fv  = ~fv;
      model_step(iv, imul, rd, fl, imv, idat, fv, fr, ffl, clr);
      step(iv, imul, rd, fl, imv, idat, fv, fr, ffl, clr);
      chk_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
